// File: rtl/bp_wb_pkg.sv
// Shared Wishbone types and constants for the I$/D$ master arbiter.
// BP_WB_ARB_TIMEOUT_EN adds the TOUT state used by the response watchdog.
package bp_wb_pkg;

`ifdef BP_WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2,
        ARB_TOUT   = 2'd3
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_e;
`endif

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_CONST   = 3'b001;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_END     = 3'b111;

    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
    localparam logic [1:0] WB_BTE_WRAP4   = 2'b01;
    localparam logic [1:0] WB_BTE_WRAP8   = 2'b10;
    localparam logic [1:0] WB_BTE_WRAP16  = 2'b11;

endpackage

// File: rtl/bp_wb_arb_rr.sv
// Two-way round-robin picker: on a tie the master not granted last wins.
module bp_wb_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/bp_wb_master_arbiter.sv
// 2:1 Wishbone B4 master arbiter (I$ = s0, D$ = s1), grant locked for the whole cyc.
// BP_WB_ARB_TIMEOUT_EN enables a per-grant response watchdog of timeout_p cycles.
module bp_wb_master_arbiter
    import bp_wb_pkg::*;
#(
    parameter  int unsigned data_width_p = 64,
    parameter  int unsigned adr_width_p  = 37,
`ifdef BP_WB_ARB_TIMEOUT_EN
    parameter  int unsigned timeout_p    = 1024,
`endif
    localparam int unsigned bus_bytes_lp = data_width_p >> 3
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic [adr_width_p-1:0]  s0_adr_i,
    input  logic [data_width_p-1:0] s0_dat_i,
    input  logic [bus_bytes_lp-1:0] s0_sel_i,
    input  logic [2:0]              s0_cti_i,
    input  logic [1:0]              s0_bte_i,
    input  logic                    s0_cyc_i,
    input  logic                    s0_stb_i,
    input  logic                    s0_we_i,
    output logic                    s0_ack_o,
    output logic                    s0_err_o,
    output logic [data_width_p-1:0] s0_dat_o,

    input  logic [adr_width_p-1:0]  s1_adr_i,
    input  logic [data_width_p-1:0] s1_dat_i,
    input  logic [bus_bytes_lp-1:0] s1_sel_i,
    input  logic [2:0]              s1_cti_i,
    input  logic [1:0]              s1_bte_i,
    input  logic                    s1_cyc_i,
    input  logic                    s1_stb_i,
    input  logic                    s1_we_i,
    output logic                    s1_ack_o,
    output logic                    s1_err_o,
    output logic [data_width_p-1:0] s1_dat_o,

    output logic [adr_width_p-1:0]  m_adr_o,
    output logic [data_width_p-1:0] m_dat_o,
    output logic [bus_bytes_lp-1:0] m_sel_o,
    output logic [2:0]              m_cti_o,
    output logic [1:0]              m_bte_o,
    output logic                    m_cyc_o,
    output logic                    m_stb_o,
    output logic                    m_we_o,
    input  logic                    m_ack_i,
    input  logic                    m_err_i,
    input  logic [data_width_p-1:0] m_dat_i
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] pick;
    logic       gnt, gsel, g_cyc, g_stb, o_cyc, g_err;

    bp_wb_arb_rr u_rr (
        .req_i   ({s1_cyc_i, s0_cyc_i}),
        .last_i  (last_q),
        .grant_o (pick)
    );

`ifdef BP_WB_ARB_TIMEOUT_EN
    localparam int unsigned cnt_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic                    tout_hit;
`endif

    assign gnt   = (state_q == ARB_GRANT0) || (state_q == ARB_GRANT1);
    assign gsel  = (state_q == ARB_GRANT1);
    assign g_cyc = gsel ? s1_cyc_i : s0_cyc_i;
    assign g_stb = gsel ? s1_stb_i : s0_stb_i;
    assign o_cyc = gsel ? s0_cyc_i : s1_cyc_i;

    // Next state plus pass-through muxing of the granted master onto the bus.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        g_err    = m_err_i;
        m_adr_o  = '0;
        m_dat_o  = '0;
        m_sel_o  = '0;
        m_cti_o  = '0;
        m_bte_o  = '0;
        m_cyc_o  = 1'b0;
        m_stb_o  = 1'b0;
        m_we_o   = 1'b0;
        s0_ack_o = 1'b0;
        s0_err_o = 1'b0;
        s1_ack_o = 1'b0;
        s1_err_o = 1'b0;
        s0_dat_o = '0;
        s1_dat_o = '0;
`ifdef BP_WB_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        tout_hit = 1'b0;
`endif

        if (gnt) begin
            m_adr_o  = gsel ? s1_adr_i : s0_adr_i;
            m_dat_o  = gsel ? s1_dat_i : s0_dat_i;
            m_sel_o  = gsel ? s1_sel_i : s0_sel_i;
            m_cti_o  = gsel ? s1_cti_i : s0_cti_i;
            m_bte_o  = gsel ? s1_bte_i : s0_bte_i;
            m_we_o   = gsel ? s1_we_i  : s0_we_i;
            m_cyc_o  = g_cyc;
            m_stb_o  = g_stb;
            s0_dat_o = m_dat_i;
            s1_dat_o = m_dat_i;
`ifdef BP_WB_ARB_TIMEOUT_EN
            tout_hit = g_cyc && g_stb && !m_ack_i && !m_err_i
                       && (cnt_q == cnt_width_lp'(timeout_p - 1));
            if (m_ack_i || m_err_i) begin
                cnt_d = '0;
            end else if (g_stb) begin
                cnt_d = cnt_q + cnt_width_lp'(1);
            end
            if (tout_hit) begin
                m_cyc_o = 1'b0;
                m_stb_o = 1'b0;
                g_err   = 1'b1;
            end
`endif
            s0_ack_o = !gsel && m_ack_i;
            s0_err_o = !gsel && g_err;
            s1_ack_o = gsel && m_ack_i;
            s1_err_o = gsel && g_err;
        end

        case (state_q)
            ARB_IDLE: begin
                if (pick[0]) begin
                    state_d = ARB_GRANT0;
                end else if (pick[1]) begin
                    state_d = ARB_GRANT1;
                end
            end
            ARB_GRANT0, ARB_GRANT1: begin
                // Hand straight over to a waiting master; no idle bubble.
                if (!g_cyc) begin
                    state_d = o_cyc ? (gsel ? ARB_GRANT0 : ARB_GRANT1) : ARB_IDLE;
                end
            end
`ifdef BP_WB_ARB_TIMEOUT_EN
            ARB_TOUT: begin
                if (!(last_q ? s1_cyc_i : s0_cyc_i)) begin
                    state_d = ARB_IDLE;
                end
            end
`endif
            default: state_d = ARB_IDLE;
        endcase

`ifdef BP_WB_ARB_TIMEOUT_EN
        if (tout_hit) begin
            state_d = ARB_TOUT;
        end
        if ((state_d == ARB_GRANT0 || state_d == ARB_GRANT1) && state_d != state_q) begin
            cnt_d = '0;
        end
`endif
        if (state_d == ARB_GRANT0) begin
            last_d = 1'b0;
        end else if (state_d == ARB_GRANT1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

`ifdef BP_WB_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: doc/bp_wb_master_arbiter.md
Name: bp_wb_master_arbiter

Overview:
- 2:1 Wishbone B4 master arbiter sitting directly downstream of the unicore-lite I$ and D$ Wishbone master ports.
- Merges the two masters onto a single LiteX-facing Wishbone master port.
- Round-robin grant, locked for the whole cyc_o assertion, so bursts and multi-beat transfers are never interleaved.
- Adds exactly one cycle of arbitration latency on a fresh grant from idle.

Parameters:
- data_width_p, 64, Wishbone data width in bits; bus_bytes_lp = data_width_p>>3.
- adr_width_p, 37, Wishbone word-address width (paddr_width_p 40 minus log2 of bus bytes).
- timeout_p, 1024, watchdog limit in cycles; used only with BP_WB_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- s0_adr_i, s0_dat_i, s0_sel_i, s0_cti_i, s0_bte_i  in  adr_width_p / data_width_p / bus_bytes_lp / 3 / 2  master 0 (I$) request fields.
- s0_cyc_i, s0_stb_i, s0_we_i  in  1 each  master 0 controls.
- s0_ack_o, s0_err_o  out  1 each  master 0 responses.
- s0_dat_o  out  data_width_p  master 0 read data.
- s1_*  identical set for master 1 (D$).
- m_adr_o, m_dat_o, m_sel_o, m_cti_o, m_bte_o, m_cyc_o, m_stb_o, m_we_o  out  same widths  merged bus request.
- m_ack_i, m_err_i  in  1 each  bus responses.
- m_dat_i  in  data_width_p  bus read data.

Behaviour:
- Single clock; reset_i is synchronous and active-high.
- States: IDLE, GRANT0, GRANT1. Registered grant; last_r records the last master granted (reset 1, so master 0 wins the first tie).
- IDLE:
  - Bus outputs all 0.
  - If exactly one sN_cyc_i=1: next state GRANTN.
  - If both: grant the master != last_r.
  - Requests are visible on m_* the cycle after they arrive (1-cycle latency).
- GRANTn:
  - m_* request fields = sN_* inputs, combinational pass-through.
  - sN_ack_o = m_ack_i and sN_err_o = m_err_i; the other master's ack/err = 0.
  - m_dat_i is broadcast to both sN_dat_o.
  - last_r <= n on entry.
- Release: when granted sN_cyc_i=0, m_cyc_o/m_stb_o drop that same cycle. Next state is:
  - GRANT(other) if the other master's cyc_i=1 (no idle bubble);
  - otherwise IDLE.
- Grant is held through any cti sequence (000/001/010/111) while cyc stays high; stb gaps inside cyc do not release.
- The non-granted master simply stalls: no ack, no err. Its inputs are ignored.
- Simultaneous release and other request: handled per the release rule. Simultaneous request from the same master in the release cycle: treated as a new request, arbitrated next cycle from IDLE.
- Reset mid-transaction: state -> IDLE and all outputs 0 the cycle after reset_i is sampled high. last_r -> 1.
- Responses with no grant are dropped: m_ack_i/m_err_i while IDLE are not forwarded.

Optional Feature:
- Macro: BP_WB_ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on grant entry and on every m_ack_i or m_err_i.
  - It increments each cycle m_stb_o=1 with no response.
  - On reaching timeout_p-1, the arbiter drives a 1-cycle sN_err_o=1 to the granted master, forces m_cyc_o=0, and goes to IDLE until that master drops cyc_i (masked state TOUT, then IDLE).
- Disabled: no counter, no TOUT state, and the arbiter waits indefinitely.

Decomposition:
- Shared package bp_wb_pkg holds:
  - the state enum for the arbiter;
  - Wishbone cti constants (classic 000, const 001, incr 010, end 111) and bte constants.
- One natural sub-module, bp_wb_arb_rr: combinational 2-way round-robin picker with inputs req[1:0] and last, outputs grant one-hot.

Test Plan:
- s0 single read of adr 0x100, m_ack_i after 2 cycles with m_dat_i=0xDEAD_BEEF -> m_cyc_o rises 1 cycle after s0_cyc_i; s0_ack_o=1 and s0_dat_o=0xDEAD_BEEF; s1_ack_o stays 0.
- Both cyc_i raised in the same cycle after reset -> s0 granted first; on s0 release s1 granted next cycle with no IDLE. A second simultaneous pair -> s0 granted again (last_r=1).
- s1 4-beat incr burst (cti 010,010,010,111) while s0 requests throughout -> all 4 beats forwarded contiguously; s0 granted only after s1_cyc_i drops.
- m_err_i=1 during s0 write of sel=0x0F -> s0_err_o=1 that cycle; grant is held until s0_cyc_i=0.
- reset_i asserted mid-burst on GRANT1 -> next cycle m_cyc_o=0, state IDLE; a following simultaneous request grants s0.
- With BP_WB_ARB_TIMEOUT_EN and timeout_p=16: s0 read never acked -> s0_err_o pulses at cycle 16 of stb, m_cyc_o=0. Without the macro, cyc stays high for 100 cycles.
